// File: rtl/pcs_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pcs_tx_sequencer
// Description : PCS transmit ordered-set sequencer. Turns the GMII transmit
//               stream into 8b/10b code groups, inserting /I/, /S/, /T/, /R/
//               and /V/ while keeping ordered sets even-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module pcs_tx_sequencer (
   input  logic        clk_125,
   input  logic        reset,
   input  logic        mac_tx_en,
   input  logic        mac_tx_er,
   input  logic [7:0]  mac_txd,
   input  logic        xcvr_tx_ready,
   output logic [7:0]  xcvr_txd,
   output logic        xcvr_tx_datak,
   output logic        tx_even,
   output logic        tx_busy,
   output logic [15:0] tx_frames,
   output logic [7:0]  tx_aborts
);

   localparam logic [7:0] COMMA_CODE = 8'hBC;
   localparam logic [7:0] IDLE_DATA  = 8'h50;
   localparam logic [7:0] SOP_CODE   = 8'hFB;
   localparam logic [7:0] EOP_CODE   = 8'hFD;
   localparam logic [7:0] EXT_CODE   = 8'hF7;
   localparam logic [7:0] ERR_CODE   = 8'hFE;
   localparam logic [7:0] ABORT_MAX  = 8'hFF;

   // The state names the code group currently on xcvr_txd.
   typedef enum logic [2:0] {
      IDLE_K = 3'd0,
      IDLE_D = 3'd1,
      SOP    = 3'd2,
      DATA   = 3'd3,
      ABORT  = 3'd4,
      EOP_T  = 3'd5,
      R1     = 3'd6,
      R2     = 3'd7
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] txd_nxt;
   logic       datak_nxt;
   logic       busy_nxt;
   logic       wait_low;

   // Next-state selection and the code group that state will place on the line.
   always_comb begin
      state_nxt = IDLE_K;
      txd_nxt   = COMMA_CODE;
      datak_nxt = 1'b1;
      busy_nxt  = 1'b1;

      case (state)
         IDLE_K: state_nxt = IDLE_D;   // octet offered here is dropped
         IDLE_D: begin
            if (mac_tx_en && xcvr_tx_ready && !wait_low)
               state_nxt = SOP;
            else
               state_nxt = IDLE_K;
         end
         SOP, DATA: begin
            // Losing the transceiver mid-frame beats a normal frame end.
            if (!xcvr_tx_ready)
               state_nxt = ABORT;
            else if (mac_tx_en)
               state_nxt = DATA;
            else
               state_nxt = EOP_T;
         end
         ABORT:   state_nxt = EOP_T;
         EOP_T:   state_nxt = R1;
         // A second /R/ is only needed when R1 sits in an even slot.
         R1:      state_nxt = tx_even ? R2 : IDLE_K;
         R2:      state_nxt = IDLE_K;
         default: state_nxt = IDLE_K;
      endcase

      case (state_nxt)
         IDLE_K: begin
            txd_nxt   = COMMA_CODE;
            datak_nxt = 1'b1;
            busy_nxt  = 1'b0;
         end
         IDLE_D: begin
            txd_nxt   = IDLE_DATA;
            datak_nxt = 1'b0;
            busy_nxt  = 1'b0;
         end
         SOP:   txd_nxt = SOP_CODE;
         DATA: begin
            txd_nxt   = mac_tx_er ? ERR_CODE : mac_txd;
            datak_nxt = mac_tx_er;
         end
         ABORT: txd_nxt = ERR_CODE;
         EOP_T: txd_nxt = EOP_CODE;
         default: txd_nxt = EXT_CODE;   // R1, R2
      endcase
   end

   // State, line outputs, slot parity and the restart-inhibit flag.
   always_ff @(posedge clk_125 or posedge reset) begin
      if (reset) begin
         state         <= IDLE_K;
         xcvr_txd      <= COMMA_CODE;
         xcvr_tx_datak <= 1'b1;
         tx_even       <= 1'b1;
         tx_busy       <= 1'b0;
         wait_low      <= 1'b0;
      end else begin
         state         <= state_nxt;
         xcvr_txd      <= txd_nxt;
         xcvr_tx_datak <= datak_nxt;
         tx_even       <= ~tx_even;
         tx_busy       <= busy_nxt;
         // Seeing mac_tx_en low ends the aborted frame, even on the abort edge.
         wait_low      <= (wait_low | (state_nxt == ABORT)) & mac_tx_en;
      end
   end

   // Frame counter wraps; abort counter saturates; each updates on its own.
   always_ff @(posedge clk_125 or posedge reset) begin
      if (reset) begin
         tx_frames <= 16'd0;
         tx_aborts <= 8'd0;
      end else begin
         if (state_nxt == EOP_T)
            tx_frames <= tx_frames + 16'd1;
         if ((state_nxt == ABORT) && (tx_aborts != ABORT_MAX))
            tx_aborts <= tx_aborts + 8'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcs_tx_sequencer
// Description : Self-checking bench for pcs_tx_sequencer. A line-level model
//               (slot index, tail queue of trailing code groups) predicts
//               every code group, flag and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcs_tx_sequencer;

   localparam logic [7:0] C_BC = 8'hBC;
   localparam logic [7:0] C_50 = 8'h50;
   localparam logic [7:0] C_FB = 8'hFB;
   localparam logic [7:0] C_FD = 8'hFD;
   localparam logic [7:0] C_F7 = 8'hF7;
   localparam logic [7:0] C_FE = 8'hFE;

   logic        clk_125 = 1'b0;
   logic        reset = 1'b1;
   logic        mac_tx_en = 1'b0;
   logic        mac_tx_er = 1'b0;
   logic [7:0]  mac_txd = 8'h00;
   logic        xcvr_tx_ready = 1'b1;
   logic [7:0]  xcvr_txd;
   logic        xcvr_tx_datak;
   logic        tx_even;
   logic        tx_busy;
   logic [15:0] tx_frames;
   logic [7:0]  tx_aborts;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: what is on the line now, plus what must follow.
   logic [7:0]  m_d;
   logic        m_k;
   logic        m_busy;
   logic        m_infr;
   logic        m_wait;
   int          m_slot;
   logic [15:0] m_frames;
   logic [7:0]  m_aborts;
   logic [8:0]  m_tail[$];

   pcs_tx_sequencer dut (
      .clk_125       (clk_125),
      .reset         (reset),
      .mac_tx_en     (mac_tx_en),
      .mac_tx_er     (mac_tx_er),
      .mac_txd       (mac_txd),
      .xcvr_tx_ready (xcvr_tx_ready),
      .xcvr_txd      (xcvr_txd),
      .xcvr_tx_datak (xcvr_tx_datak),
      .tx_even       (tx_even),
      .tx_busy       (tx_busy),
      .tx_frames     (tx_frames),
      .tx_aborts     (tx_aborts)
   );

   always #5 clk_125 = ~clk_125;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_d = C_BC; m_k = 1'b1; m_busy = 1'b0; m_infr = 1'b0; m_wait = 1'b0;
      m_slot = 0; m_frames = 16'd0; m_aborts = 8'd0;
      m_tail.delete();
   endtask

   // Append /R/ groups so the idle after them starts on an even slot,
   // given the slot index that carries /T/.
   task automatic add_ext(input int fd_slot);
      int r;
      r = ((fd_slot % 2) == 0) ? 1 : 2;
      repeat (r) m_tail.push_back({1'b1, C_F7});
   endtask

   task automatic model_step();
      logic [8:0] nx;
      logic       ab;
      logic       nb;
      m_slot++;
      ab = 1'b0;
      nb = 1'b1;
      if (m_tail.size() > 0) begin
         nx = m_tail.pop_front();
      end else if (m_infr) begin
         if (!xcvr_tx_ready) begin
            nx = {1'b1, C_FE};
            ab = 1'b1;
            m_infr = 1'b0;
            m_tail.push_back({1'b1, C_FD});
            add_ext(m_slot + 1);
         end else if (mac_tx_en) begin
            nx = mac_tx_er ? {1'b1, C_FE} : {1'b0, mac_txd};
         end else begin
            nx = {1'b1, C_FD};
            m_infr = 1'b0;
            add_ext(m_slot);
         end
      end else if (m_busy) begin
         nx = {1'b1, C_BC};
         nb = 1'b0;
      end else if (m_k) begin
         nx = {1'b0, C_50};
         nb = 1'b0;
      end else if (mac_tx_en && xcvr_tx_ready && !m_wait) begin
         nx = {1'b1, C_FB};
         m_infr = 1'b1;
      end else begin
         nx = {1'b1, C_BC};
         nb = 1'b0;
      end
      if (nx == {1'b1, C_FD}) m_frames = m_frames + 16'd1;
      if (ab && (m_aborts != 8'hFF)) m_aborts = m_aborts + 8'd1;
      m_wait = (m_wait | ab) & mac_tx_en;
      m_k    = nx[8];
      m_d    = nx[7:0];
      m_busy = nb;
   endtask

   task automatic compare();
      check("txd",    xcvr_txd,      m_d);
      check("datak",  xcvr_tx_datak, m_k);
      check("even",   tx_even,       ((m_slot % 2) == 0));
      check("busy",   tx_busy,       m_busy);
      check("frames", tx_frames,     m_frames);
      check("aborts", tx_aborts,     m_aborts);
   endtask

   task automatic step();
      @(posedge clk_125);
      model_step();
      #1;
      compare();
   endtask

   task automatic drive(input logic en, input logic er, input logic [7:0] d, input logic rdy);
      mac_tx_en = en; mac_tx_er = er; mac_txd = d; xcvr_tx_ready = rdy;
      step();
   endtask

   // Idle until the line shows /I/ first half (want_k=1) or second half.
   task automatic align(input logic want_k);
      for (int i = 0; i < 6 && !(!m_busy && (m_k == want_k)); i++)
         drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("align", {tx_busy, xcvr_tx_datak}, {1'b0, want_k});
   endtask

   task automatic std_frame(input int er_idx, input int nrdy_idx);
      logic [7:0] oct[5];
      oct[0] = 8'h55; oct[1] = 8'h01; oct[2] = 8'h02; oct[3] = 8'h03; oct[4] = 8'h04;
      for (int i = 0; i < 5; i++)
         drive(1'b1, (i == er_idx), oct[i], (i != nrdy_idx));
   endtask

   initial begin
      model_reset();
      #12;
      compare();
      @(posedge clk_125);
      #2 reset = 1'b0;

      // Idle stream after reset.
      repeat (8) drive(1'b0, 1'b0, 8'h00, 1'b1);

      // Frame started in the second half of /I/.
      align(1'b0);
      std_frame(-1, -1);
      repeat (6) drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("frames_1", tx_frames, 32'd1);

      // Frame started in the first half of /I/: first octet lost.
      align(1'b1);
      std_frame(-1, -1);
      repeat (6) drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("frames_2", tx_frames, 32'd2);

      // Error on the third data octet.
      align(1'b0);
      std_frame(3, -1);
      repeat (6) drive(1'b0, 1'b0, 8'h00, 1'b1);

      // Transceiver drops on the second data octet; MAC keeps sending.
      align(1'b0);
      std_frame(-1, 2);
      repeat (8) drive(1'b1, 1'b0, 8'hA5, 1'b1);
      check("aborts_1", tx_aborts, 32'd1);
      repeat (6) drive(1'b0, 1'b0, 8'h00, 1'b1);

      // Randomized frames, errors, ready drops and gaps.
      for (int f = 0; f < 60; f++) begin
         int len;
         len = $urandom_range(1, 14);
         for (int i = 0; i < len; i++)
            drive(1'b1, ($urandom_range(0, 9) == 0), 8'($urandom), ($urandom_range(0, 15) != 0));
         repeat ($urandom_range(1, 6))
            drive(1'b0, 1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
      end

      // Reset in the middle of a frame.
      align(1'b0);
      drive(1'b1, 1'b0, 8'h11, 1'b1);
      drive(1'b1, 1'b0, 8'h22, 1'b1);
      drive(1'b1, 1'b0, 8'h33, 1'b1);
      #2 reset = 1'b1;
      #1;
      model_reset();
      compare();
      mac_tx_en = 1'b0;
      @(posedge clk_125);
      #2 reset = 1'b0;
      repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b1);

      // Drive the abort counter into saturation.
      for (int a = 0; a < 260; a++) begin
         repeat (5) drive(1'b0, 1'b0, 8'h00, 1'b1);
         repeat (3) drive(1'b1, 1'b0, 8'($urandom), 1'b1);
         drive(1'b1, 1'b0, 8'h00, 1'b0);
         drive(1'b0, 1'b0, 8'h00, 1'b1);
      end
      repeat (6) drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("aborts_sat", tx_aborts, 32'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
